shot_responder: RTL and testbench
=================================

// Module: shot_responder
// PURPOSE
//   Answers the opponent's shots on our own board. It synchronises the inter-board link
//   (ready2, ship_cords_in) and checks the addressed cell in my board_mem (port 1).
//   It writes HIT or MISS back to that cell, then acknowledges with ready1/hit1 using
//   a 4-phase handshake. Sits beside main_fsm on control_clk and owns my_mem port 1
//   while en=1.
// PARAMETERS
//   SYNC_STAGES   2   flip-flop stages on ready2 and ship_cords_in
//   STABLE_CYC    4   cycles ship_cords_in must stay unchanged before sampling
//   X_SIZE        12  board columns; x >= X_SIZE is out of range
//   Y_SIZE        12  board rows; y >= Y_SIZE is out of range
//   SHIP_CELLS    20  ship cells on our board at game start
// PORTS
//   clk            in   1  control clock
//   rst            in   1  asynchronous reset, active-low
//   en             in   1  main_fsm grants responding (enemy's turn)
//   ready2         in   1  opponent shot request (async, level)
//   ship_cords_in  in   8  shot coordinates {y[3:0], x[3:0]} (async)
//   mem_addr       out  8  board_mem addr1 = {y, x}
//   mem_data_in    in   2  board_mem read_data1, valid 1 cycle after mem_addr
//   mem_data_out   out  2  board_mem write_data1
//   mem_w_nr       out  1  board_mem write strobe (1 = write)
//   ready1         out  1  acknowledge to opponent
//   hit1           out  1  shot result, valid while ready1=1
//   cells_left     out  5  remaining unhit ship cells
//   all_sunk       out  1  cells_left == 0
//   shot_done      out  1  1-cycle pulse per completed response
//   coord_err      out  1  1-cycle pulse: out-of-range coordinates received
// BEHAVIOUR
//   Cell encoding: 00 EMPTY, 01 SHIP, 10 MISS, 11 HIT.
//   Reset values: ready1=0, hit1=0, mem_w_nr=0, mem_addr=0, mem_data_out=0,
//     cells_left=SHIP_CELLS, shot_done=0, coord_err=0, FSM in IDLE,
//     synchroniser flops cleared.
//   All logic uses only the synchronised copies of ready2 and ship_cords_in.
//   FSM:
//     IDLE:   if en & ready2_s -> STABLE; reset stability counter.
//     STABLE: count cycles with cords_s unchanged; any change restarts the count.
//             At STABLE_CYC: latch the coordinates.
//             If out of range -> ACK with hit1=0 and a coord_err pulse; else -> READ.
//             ready2_s falling here -> IDLE with no response.
//     READ:   drive mem_addr={y,x}, mem_w_nr=0 -> EVAL (1-cycle read latency).
//     EVAL:   SHIP  -> hit=1, write HIT, cells_left-1 (saturates at 0);
//             EMPTY -> hit=0, write MISS;
//             HIT   -> hit=1, no write, no count change;
//             MISS  -> hit=0, no write.
//             Next state: WRITE if a write is needed, else ACK.
//     WRITE:  mem_w_nr=1 for exactly one cycle, mem_data_out as above -> ACK.
//     ACK:    ready1=1, hit1=result; both held until ready2_s=0.
//             Then ready1=0, hit1=0, a shot_done pulse, and -> IDLE.
//   en dropping mid-shot does not abort it; the current response completes.
//   The next shot needs ready2_s to be seen low then high again (no re-trigger in ACK).
//   ready2 held high across reset: the shot is taken after reset, once en=1.
//   Reset asserted mid-operation: everything returns to reset values immediately;
//     a write in progress is dropped.
//   Latency, ready2_s high to ready1 high: STABLE_CYC + 3 cycles with a write,
//     STABLE_CYC + 2 without.
// TESTING
//   1. cell (3,5)=SHIP, ready2 high with cords=8'h53 -> one write of 11 at addr 8'h53;
//      ready1=1, hit1=1, cells_left 20->19; drop ready2 -> ready1=0 and a shot_done pulse.
//   2. cell (0,0)=EMPTY, shot 8'h00 -> write 10 at 8'h00, hit1=0, cells_left unchanged.
//   3. repeat shot at 8'h53 (now HIT) -> no write strobe, hit1=1, cells_left stays 19.
//   4. cords=8'h0C (x=12) -> coord_err pulse, hit1=0, mem_w_nr never asserted.
//   5. cords toggle every 2 cycles, then settle -> sampled only after 4 stable
//      synchronised cycles; final value used.
//   6. rst low during WRITE -> all outputs at reset values next cycle;
//      en=0 with ready2=1 -> no memory access.

Source files
------------

// File: rtl/shot_responder.sv
// ---------------------------------------------------------------------------
// shot_responder
//   Answers the opponent's shots on our own board. The inter-board link
//   (ready2, ship_cords_in) is resynchronised. Once the coordinates have
//   stayed unchanged long enough, the addressed cell of board_mem (port 1)
//   is read and marked HIT or MISS. The result is then returned on
//   ready1/hit1 with a 4-phase handshake. The block owns board_mem port 1
//   while en=1.
//
// Ports
//   clk            control clock
//   rst            asynchronous reset, active-low
//   en             responding granted by main_fsm (enemy's turn)
//   ready2         opponent shot request (asynchronous level)
//   ship_cords_in  shot coordinates {y[3:0], x[3:0]} (asynchronous)
//   mem_addr       board_mem addr1 = {y, x}
//   mem_data_in    board_mem read_data1, valid one cycle after mem_addr
//   mem_data_out   board_mem write_data1
//   mem_w_nr       board_mem write strobe (1 = write)
//   ready1         acknowledge to opponent
//   hit1           shot result, valid while ready1=1
//   cells_left     remaining unhit ship cells
//   all_sunk       cells_left == 0
//   shot_done      one-cycle pulse per completed response
//   coord_err      one-cycle pulse when out-of-range coordinates arrive
// ---------------------------------------------------------------------------
module shot_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 4,
  parameter int X_SIZE      = 12,
  parameter int Y_SIZE      = 12,
  parameter int SHIP_CELLS  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ready2,
  input  logic [7:0] ship_cords_in,
  output logic [7:0] mem_addr,
  input  logic [1:0] mem_data_in,
  output logic [1:0] mem_data_out,
  output logic       mem_w_nr,
  output logic       ready1,
  output logic       hit1,
  output logic [4:0] cells_left,
  output logic       all_sunk,
  output logic       shot_done,
  output logic       coord_err
);

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;
  localparam int         CNT_W      = $clog2(STABLE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    STABLE,
    READ,
    EVAL,
    WRITE,
    ACK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] stab_cnt, cnt_nxt;
  logic [7:0]       cords_prev, prev_nxt;
  logic [7:0]       addr_nxt;
  logic [1:0]       wdata_nxt;
  logic             wr_nxt;
  logic             ready1_nxt, hit1_nxt;
  logic             hit_res, hit_nxt;
  logic [4:0]       cells_nxt;
  logic             done_nxt, err_nxt;

  logic [SYNC_STAGES-1:0] ready2_sync;
  logic [7:0]             cords_sync [SYNC_STAGES];
  logic                   ready2_s;
  logic [7:0]             cords_s;

  function automatic logic out_of_range(input logic [7:0] c);
    return (int'(c[3:0]) >= X_SIZE) || (int'(c[7:4]) >= Y_SIZE);
  endfunction

  function automatic logic [4:0] sat_dec(input logic [4:0] v);
    return (v == 5'd0) ? 5'd0 : v - 5'd1;
  endfunction

  // Synchroniser stages: ready2 and the coordinate bus. The coordinate bits
  // may resolve on different cycles; the stability counter hides that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready2_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) cords_sync[i] <= '0;
    end else begin
      ready2_sync[0] <= ready2;
      cords_sync[0]  <= ship_cords_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ready2_sync[i] <= ready2_sync[i-1];
        cords_sync[i]  <= cords_sync[i-1];
      end
    end
  end

  assign ready2_s = ready2_sync[SYNC_STAGES-1];
  assign cords_s  = cords_sync[SYNC_STAGES-1];
  assign all_sunk = (cells_left == 5'd0);

  // Next-state and next-output decode. All outputs are registered, so each
  // one is set on the transition into the state that owns it.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = stab_cnt;
    prev_nxt   = cords_prev;
    addr_nxt   = mem_addr;
    wr_nxt     = 1'b0;
    wdata_nxt  = 2'b00;
    ready1_nxt = ready1;
    hit1_nxt   = hit1;
    hit_nxt    = hit_res;
    cells_nxt  = cells_left;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (en && ready2_s) begin
          state_nxt = STABLE;
          cnt_nxt   = CNT_W'(1);
          prev_nxt  = cords_s;
        end
      end
      STABLE: begin
        // stab_cnt is the number of consecutive cycles cords_s has held
        // its current value, counting the IDLE cycle that started the shot.
        if (!ready2_s) begin
          state_nxt = IDLE;
        end else if (cords_s != cords_prev) begin
          prev_nxt = cords_s;
          cnt_nxt  = CNT_W'(1);
        end else if (stab_cnt >= CNT_W'(STABLE_CYC - 1)) begin
          if (out_of_range(cords_s)) begin
            state_nxt  = ACK;
            ready1_nxt = 1'b1;
            hit1_nxt   = 1'b0;
            err_nxt    = 1'b1;
          end else begin
            state_nxt = READ;
            addr_nxt  = cords_s;
          end
        end else begin
          cnt_nxt = stab_cnt + CNT_W'(1);
        end
      end
      READ: begin
        state_nxt = EVAL;
      end
      EVAL: begin
        case (mem_data_in)
          CELL_SHIP: begin
            hit_nxt   = 1'b1;
            cells_nxt = sat_dec(cells_left);
            wr_nxt    = 1'b1;
            wdata_nxt = CELL_HIT;
            state_nxt = WRITE;
          end
          CELL_EMPTY: begin
            hit_nxt   = 1'b0;
            wr_nxt    = 1'b1;
            wdata_nxt = CELL_MISS;
            state_nxt = WRITE;
          end
          CELL_HIT: begin
            hit_nxt    = 1'b1;
            ready1_nxt = 1'b1;
            hit1_nxt   = 1'b1;
            state_nxt  = ACK;
          end
          default: begin
            hit_nxt    = 1'b0;
            ready1_nxt = 1'b1;
            hit1_nxt   = 1'b0;
            state_nxt  = ACK;
          end
        endcase
      end
      WRITE: begin
        ready1_nxt = 1'b1;
        hit1_nxt   = hit_res;
        state_nxt  = ACK;
      end
      ACK: begin
        // Leaving only on ready2_s low means IDLE needs a fresh rising
        // request before another shot is taken.
        if (!ready2_s) begin
          ready1_nxt = 1'b0;
          hit1_nxt   = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Register stage: FSM state, handshake and memory-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      stab_cnt     <= '0;
      cords_prev   <= '0;
      mem_addr     <= '0;
      mem_w_nr     <= 1'b0;
      mem_data_out <= '0;
      ready1       <= 1'b0;
      hit1         <= 1'b0;
      hit_res      <= 1'b0;
      cells_left   <= 5'(SHIP_CELLS);
      shot_done    <= 1'b0;
      coord_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      stab_cnt     <= cnt_nxt;
      cords_prev   <= prev_nxt;
      mem_addr     <= addr_nxt;
      mem_w_nr     <= wr_nxt;
      mem_data_out <= wdata_nxt;
      ready1       <= ready1_nxt;
      hit1         <= hit1_nxt;
      hit_res      <= hit_nxt;
      cells_left   <= cells_nxt;
      shot_done    <= done_nxt;
      coord_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_shot_responder.sv
// ---------------------------------------------------------------------------
// tb_shot_responder
//   Self-checking bench for shot_responder. A behavioural board_mem model
//   answers port 1; a reference board plus ship counter predicts each
//   response. Predictions are queued when a shot is driven and compared when
//   ready1 rises.
// ---------------------------------------------------------------------------
module tb_shot_responder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ready2;
  logic [7:0] ship_cords_in;
  logic [7:0] mem_addr;
  logic [1:0] mem_data_in;
  logic [1:0] mem_data_out;
  logic       mem_w_nr;
  logic       ready1;
  logic       hit1;
  logic [4:0] cells_left;
  logic       all_sunk;
  logic       shot_done;
  logic       coord_err;

  shot_responder dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ready2       (ready2),
    .ship_cords_in(ship_cords_in),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_w_nr     (mem_w_nr),
    .ready1       (ready1),
    .hit1         (hit1),
    .cells_left   (cells_left),
    .all_sunk     (all_sunk),
    .shot_done    (shot_done),
    .coord_err    (coord_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic       err;
    int         wr;
    logic [7:0] addr;
    logic [1:0] data;
    int         cells;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_err    = 0;
  int         exp_cells;
  logic [1:0] ref_board [256];
  logic [1:0] board [256];
  logic       mem_load;

  int         wr_cnt;
  logic [7:0] wr_addr;
  logic [1:0] wr_data;
  logic       err_seen;
  logic       r1_q;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] init_val(input logic [7:0] a);
    logic [3:0] x;
    logic [3:0] y;
    x = a[3:0];
    y = a[7:4];
    if (a == 8'h53 || a == 8'h34 || a == 8'h77 ||
        (y == 4'd10 && x < 4'd12) || (y == 4'd11 && x < 4'd8))
      return 2'b01;
    return 2'b00;
  endfunction

  // board_mem port 1 model: registered read, write on strobe.
  always @(posedge clk) begin
    mem_data_in <= board[mem_addr];
    if (mem_load) begin
      for (int i = 0; i < 256; i++) board[i] <= init_val(8'(i));
    end else if (mem_w_nr) begin
      board[mem_addr] <= mem_data_out;
    end
  end

  // Output monitor: gathers writes/errors of the current shot and compares
  // against the queued prediction when ready1 rises.
  always @(negedge clk) begin
    if (!rst) begin
      wr_cnt   = 0;
      err_seen = 1'b0;
      r1_q     = 1'b0;
    end else begin
      if (mem_w_nr) begin
        wr_cnt++;
        wr_addr = mem_addr;
        wr_data = mem_data_out;
      end
      if (coord_err) err_seen = 1'b1;
      if (ready1 && !r1_q) begin
        chk("sb_nonempty", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          chk("hit1", hit1, mon_e.hit);
          chk("coord_err", err_seen, mon_e.err);
          chk("wr_count", wr_cnt, mon_e.wr);
          if (mon_e.wr != 0) begin
            chk("wr_addr", wr_addr, mon_e.addr);
            chk("wr_data", wr_data, mon_e.data);
          end
          chk("cells_left", cells_left, mon_e.cells);
          chk("all_sunk", all_sunk, int'(mon_e.cells == 0));
        end
        wr_cnt   = 0;
        err_seen = 1'b0;
      end
      r1_q = ready1;
    end
  end

  // Predict the response to a shot at c and queue it; lat is the expected
  // number of clock edges from driving ready2 to seeing ready1.
  task automatic push_exp(input logic [7:0] c, output int lat);
    exp_t e;
    e.addr = c;
    e.hit  = 1'b0;
    e.err  = 1'b0;
    e.wr   = 0;
    e.data = 2'b00;
    if (c[3:0] >= 4'd12 || c[7:4] >= 4'd12) begin
      e.err = 1'b1;
      lat   = 6;
    end else begin
      case (ref_board[c])
        2'b01: begin
          e.hit = 1'b1; e.wr = 1; e.data = 2'b11;
          exp_cells = (exp_cells == 0) ? 0 : exp_cells - 1;
          ref_board[c] = 2'b11;
          lat = 9;
        end
        2'b00: begin
          e.wr = 1; e.data = 2'b10;
          ref_board[c] = 2'b10;
          lat = 9;
        end
        2'b11: begin
          e.hit = 1'b1;
          lat = 8;
        end
        default: lat = 8;
      endcase
    end
    e.cells = exp_cells;
    sbq.push_back(e);
  endtask

  task automatic wait_ack(output int lat, input bit drop_en);
    lat = 0;
    while (!ready1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (drop_en && lat == 3) en = 1'b0;
    end
    en = 1'b1;
    chk("ack_seen", ready1, 1);
  endtask

  task automatic release_shot();
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("ack_hold", ready1, 1);
    ready2 = 1'b0;
    n = 0;
    while (ready1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_release", ready1, 0);
    chk("done_pulse", shot_done, 1);
    @(posedge clk); #1;
    chk("done_width", shot_done, 0);
    chk("hit1_clear", hit1, 0);
  endtask

  // ntog > 0 first toggles the coordinates every two cycles before settling.
  task automatic shot(input logic [7:0] c, input int ntog, input bit drop_en);
    int exp_lat;
    int lat;
    push_exp(c, exp_lat);
    @(posedge clk); #1;
    ready2 = 1'b1;
    for (int i = 0; i < ntog; i++) begin
      ship_cords_in = (i % 2 == 0) ? 8'h21 : 8'h12;
      repeat (2) @(posedge clk);
      #1;
    end
    ship_cords_in = c;
    wait_ack(lat, drop_en);
    if (ntog == 0) chk("latency", lat, exp_lat);
    release_shot();
  endtask

  initial begin
    int  n;
    int  lat;
    int  dummy;
    bit  seen_w;
    bit  seen_addr;
    bit  seen_r1;
    rst           = 1'b0;
    en            = 1'b0;
    ready2        = 1'b0;
    ship_cords_in = 8'h00;
    mem_load      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_load = 1'b0;
    chk("rst_ready1", ready1, 0);
    chk("rst_hit1", hit1, 0);
    chk("rst_mem_w_nr", mem_w_nr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_out", mem_data_out, 0);
    chk("rst_cells_left", cells_left, 20);
    chk("rst_all_sunk", all_sunk, 0);
    chk("rst_shot_done", shot_done, 0);
    chk("rst_coord_err", coord_err, 0);
    exp_cells = 20;
    for (int i = 0; i < 256; i++) ref_board[i] = init_val(8'(i));
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk); #1;

    // Ship hit, empty cell (en dropped mid-shot), repeat on HIT, bad coords.
    shot(8'h53, 0, 1'b0);
    chk("mem_53", board[8'h53], 3);
    shot(8'h00, 0, 1'b1);
    chk("mem_00", board[8'h00], 2);
    shot(8'h53, 0, 1'b0);
    shot(8'h0C, 0, 1'b0);
    // Coordinates unsettled for a while: only the final value is used.
    shot(8'h34, 3, 1'b0);
    chk("mem_21_untouched", board[8'h21], 0);
    chk("mem_12_untouched", board[8'h12], 0);

    // Reset during WRITE, then ready2 held across reset with en low.
    @(posedge clk); #1;
    ship_cords_in = 8'h77;
    ready2        = 1'b1;
    n = 0;
    while (!mem_w_nr && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("write_reached", mem_w_nr, 1);
    #2;
    rst = 1'b0;
    en  = 1'b0;
    #1;
    chk("mid_rst_ready1", ready1, 0);
    chk("mid_rst_mem_w_nr", mem_w_nr, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_data_out", mem_data_out, 0);
    chk("mid_rst_cells_left", cells_left, 20);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_cells = 20;
    chk("write_dropped", board[8'h77], 1);
    seen_w    = 1'b0;
    seen_addr = 1'b0;
    seen_r1   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      seen_w    = seen_w | mem_w_nr;
      seen_addr = seen_addr | (mem_addr != 8'h00);
      seen_r1   = seen_r1 | ready1;
    end
    chk("en0_no_write", seen_w, 0);
    chk("en0_no_addr", seen_addr, 0);
    chk("en0_no_ack", seen_r1, 0);
    push_exp(8'h77, dummy);
    en = 1'b1;
    wait_ack(lat, 1'b0);
    release_shot();

    // Sink the remaining ships; the last shot exercises saturation at 0.
    for (int i = 0; i < 20; i++) begin
      int x;
      int y;
      y = (i < 12) ? 10 : 11;
      x = (i < 12) ? i : i - 12;
      shot(8'((y << 4) | x), 0, 1'b0);
    end
    chk("end_all_sunk", all_sunk, 1);
    chk("end_cells_left", cells_left, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
